// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler
//   Shares one serial UART transmit line between N_REQ requesters. A
//   round-robin arbiter picks a requester while idle, latches its byte and
//   sends start, data LSB-first, optional parity, stop, then GAP_BITS idle
//   bit times. One bit time is one clk_uart cycle.
// Ports
//   clk_uart    bit-rate clock, everything on posedge
//   rst         asynchronous, active-high reset
//   req_valid   per-requester byte available
//   req_data    byte of requester i at [i*DATA_W +: DATA_W]
//   req_ready   one-hot accept strobe (combinational, only in IDLE)
//   grant_id    index of the requester owning the current/last frame
//   busy        high from the start bit through the last gap cycle
//   frame_done  one-cycle pulse during the stop bit
//   tx          serial line, idle high
module uart_tx_scheduler #(
  parameter int N_REQ      = 4,
  parameter int DATA_W     = 8,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int GAP_BITS   = 1
) (
  input  logic                       clk_uart,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*DATA_W-1:0]    req_data,
  output logic [N_REQ-1:0]           req_ready,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       busy,
  output logic                       frame_done,
  output logic                       tx
);

  localparam int ID_W    = $clog2(N_REQ);
  localparam int CNT_MAX = (DATA_W > GAP_BITS) ? DATA_W : GAP_BITS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_GAP    = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_q, par_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ID_W-1:0]   last_q, last_d;
  logic [ID_W-1:0]   grant_id_q, grant_id_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              frame_done_q, frame_done_d;

  logic [ID_W-1:0]   winner;
  logic              any_valid;
  logic [DATA_W-1:0] sel_data;

  // Round-robin search: the first valid index strictly after the last
  // winner, wrapping around, so the last winner has lowest priority.
  always_comb begin
    int idx;
    idx       = 0;
    winner    = last_q;
    any_valid = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = int'(last_q) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!any_valid && req_valid[idx]) begin
        any_valid = 1'b1;
        winner    = ID_W'(idx);
      end
    end
    sel_data = req_data[int'(winner)*DATA_W +: DATA_W];
  end

  // Accept strobe is gated with rst so no transfer is signalled while the
  // state register is held in reset.
  always_comb begin
    req_ready = '0;
    if (state_q == S_IDLE && !rst && any_valid) req_ready[winner] = 1'b1;
  end

  // Next-state logic. tx_d is the line value for the state being entered,
  // so tx comes straight from a flop. Parity is captured together with the
  // byte because the shift register is consumed while serialising.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    par_d      = par_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    grant_id_d = grant_id_q;
    tx_d       = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (any_valid) begin
          state_d    = S_START;
          shift_d    = sel_data;
          par_d      = (PARITY_ODD != 0) ? ~^sel_data : ^sel_data;
          grant_id_d = winner;
          last_d     = winner;
          tx_d       = 1'b0;
        end
      end
      S_START: begin
        state_d = S_DATA;
        cnt_d   = '0;
        tx_d    = shift_q[0];
        shift_d = shift_q >> 1;
      end
      S_DATA: begin
        if (cnt_q == CNT_W'(DATA_W - 1)) begin
          cnt_d = '0;
          if (PARITY_EN != 0) begin
            state_d = S_PARITY;
            tx_d    = par_q;
          end else begin
            state_d = S_STOP;
          end
        end else begin
          cnt_d   = cnt_q + 1'b1;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
        end
      end
      S_PARITY: state_d = S_STOP;
      S_STOP: begin
        cnt_d   = '0;
        state_d = (GAP_BITS > 0) ? S_GAP : S_IDLE;
      end
      S_GAP: begin
        if (cnt_q == CNT_W'(GAP_BITS - 1)) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d       = (state_d != S_IDLE);
    frame_done_d = (state_d == S_STOP);
  end

  // Last winner resets to N_REQ-1 so requester 0 has top priority.
  always_ff @(posedge clk_uart or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      shift_q      <= '0;
      par_q        <= 1'b0;
      cnt_q        <= '0;
      last_q       <= ID_W'(N_REQ - 1);
      grant_id_q   <= '0;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      cnt_q        <= cnt_d;
      last_q       <= last_d;
      grant_id_q   <= grant_id_d;
      tx_q         <= tx_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign grant_id   = grant_id_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign tx         = tx_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler
//   Drives three scheduler configurations: default (even parity, 1 gap bit),
//   no parity with no gap, and odd parity. Expected frames are queued when a
//   request is driven and compared bit by bit when the frame appears on tx.
module tb_uart_tx_scheduler;

  logic       clk_uart = 1'b0;
  logic       rst;
  logic [3:0] valid_v [3];
  logic [31:0] data_v [3];
  logic [3:0] ready_v [3];
  logic [1:0] grant_v [3];
  logic       busy_v [3];
  logic       done_v [3];
  logic       tx_v [3];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_start [3];

  typedef struct {
    int         inst;
    int         id;
    logic [7:0] data;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk_uart = ~clk_uart;
  always @(posedge clk_uart) cyc = cyc + 1;

  uart_tx_scheduler #(.N_REQ(4), .DATA_W(8), .PARITY_EN(1), .PARITY_ODD(0), .GAP_BITS(1)) dut0 (
    .clk_uart(clk_uart), .rst(rst), .req_valid(valid_v[0]), .req_data(data_v[0]),
    .req_ready(ready_v[0]), .grant_id(grant_v[0]), .busy(busy_v[0]),
    .frame_done(done_v[0]), .tx(tx_v[0]));

  uart_tx_scheduler #(.N_REQ(4), .DATA_W(8), .PARITY_EN(0), .PARITY_ODD(0), .GAP_BITS(0)) dut1 (
    .clk_uart(clk_uart), .rst(rst), .req_valid(valid_v[1]), .req_data(data_v[1]),
    .req_ready(ready_v[1]), .grant_id(grant_v[1]), .busy(busy_v[1]),
    .frame_done(done_v[1]), .tx(tx_v[1]));

  uart_tx_scheduler #(.N_REQ(4), .DATA_W(8), .PARITY_EN(1), .PARITY_ODD(1), .GAP_BITS(1)) dut2 (
    .clk_uart(clk_uart), .rst(rst), .req_valid(valid_v[2]), .req_data(data_v[2]),
    .req_ready(ready_v[2]), .grant_id(grant_v[2]), .busy(busy_v[2]),
    .frame_done(done_v[2]), .tx(tx_v[2]));

  function automatic bit parity_on(input int inst);
    return inst != 1;
  endfunction

  function automatic logic parity_of(input int inst, input logic [7:0] d);
    return (inst == 2) ? ~^d : ^d;
  endfunction

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Raise a request and queue the frame it should produce.
  task automatic applyStimulus(input int inst, input int id, input logic [7:0] d);
    exp_t e;
    data_v[inst][id*8 +: 8] = d;
    valid_v[inst][id] = 1'b1;
    e.inst = inst;
    e.id   = id;
    e.data = d;
    sb_q.push_back(e);
  endtask

  // Pop the next expected frame, wait for its start bit and compare every
  // bit time through the stop bit.
  task automatic checkOutput(input bit release_req, input bit scramble, input int exp_spacing);
    exp_t       e;
    bit         saw_idle;
    bit         found;
    logic [3:0] last_ready;
    if (sb_q.size() == 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_empty observed=0 expected=1");
      return;
    end
    e = sb_q.pop_front();
    saw_idle   = 1'b0;
    found      = 1'b0;
    last_ready = '0;
    #1;
    for (int c = 0; c < 80; c++) begin
      if (busy_v[e.inst]) begin
        if (saw_idle) begin
          found = 1'b1;
          break;
        end
      end else begin
        saw_idle   = 1'b1;
        last_ready = ready_v[e.inst];
      end
      @(negedge clk_uart); #1;
    end
    checkVal($sformatf("frame_start_seen_i%0d", e.inst), 32'(found), 32'd1);
    if (!found) return;
    checkVal("start_bit", 32'(tx_v[e.inst]), 32'd0);
    checkVal("grant_id", 32'(grant_v[e.inst]), 32'(e.id));
    checkVal("req_ready_onehot", 32'(last_ready), 32'(4'b0001 << e.id));
    checkVal("done_low_at_start", 32'(done_v[e.inst]), 32'd0);
    if (exp_spacing != 0) checkVal("accept_spacing", 32'(cyc - last_start[e.inst]), 32'(exp_spacing));
    last_start[e.inst] = cyc;
    if (release_req) valid_v[e.inst][e.id] = 1'b0;
    if (scramble) data_v[e.inst][e.id*8 +: 8] = ~e.data;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk_uart); #1;
      checkVal($sformatf("data_bit%0d", k), 32'(tx_v[e.inst]), 32'(e.data[k]));
    end
    if (parity_on(e.inst)) begin
      @(negedge clk_uart); #1;
      checkVal("parity_bit", 32'(tx_v[e.inst]), 32'(parity_of(e.inst, e.data)));
    end
    @(negedge clk_uart); #1;
    checkVal("stop_bit", 32'(tx_v[e.inst]), 32'd1);
    checkVal("frame_done", 32'(done_v[e.inst]), 32'd1);
    checkVal("busy_at_stop", 32'(busy_v[e.inst]), 32'd1);
  endtask

  initial begin
    bit got_busy;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      valid_v[i]    = '0;
      data_v[i]     = '0;
      last_start[i] = 0;
    end
    repeat (2) @(negedge clk_uart);
    #1;
    checkVal("rst_tx", 32'(tx_v[0]), 32'd1);
    checkVal("rst_busy", 32'(busy_v[0]), 32'd0);
    checkVal("rst_done", 32'(done_v[0]), 32'd0);
    checkVal("rst_grant", 32'(grant_v[0]), 32'd0);
    valid_v[0][2] = 1'b1;
    #1;
    checkVal("rst_ready_gated", 32'(ready_v[0]), 32'd0);
    valid_v[0][2] = 1'b0;
    @(negedge clk_uart);
    rst = 1'b0;

    // 8'hA5 from requester 0, byte changed while it is being serialised
    @(negedge clk_uart);
    applyStimulus(0, 0, 8'hA5);
    checkOutput(1'b1, 1'b1, 0);
    repeat (3) @(negedge clk_uart);
    #1;
    checkVal("idle_tx", 32'(tx_v[0]), 32'd1);
    checkVal("idle_busy", 32'(busy_v[0]), 32'd0);

    // Reset in the middle of a data bit
    @(negedge clk_uart);
    data_v[0][23:16] = 8'h3C;
    valid_v[0][2]    = 1'b1;
    got_busy         = 1'b0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (busy_v[0]) begin
        got_busy = 1'b1;
        break;
      end
      @(negedge clk_uart);
    end
    checkVal("midframe_busy_seen", 32'(got_busy), 32'd1);
    @(negedge clk_uart); #1;
    checkVal("pre_rst_data_bit0", 32'(tx_v[0]), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    checkVal("async_rst_tx", 32'(tx_v[0]), 32'd1);
    checkVal("async_rst_busy", 32'(busy_v[0]), 32'd0);
    checkVal("async_rst_ready", 32'(ready_v[0]), 32'd0);
    checkVal("async_rst_done", 32'(done_v[0]), 32'd0);
    checkVal("async_rst_grant", 32'(grant_v[0]), 32'd0);
    valid_v[0] = '0;
    @(negedge clk_uart);
    rst = 1'b0;

    // All four requesters valid: grants 0,1,2,3,0 spaced 13 cycles
    @(negedge clk_uart);
    applyStimulus(0, 0, 8'h11);
    applyStimulus(0, 1, 8'h22);
    applyStimulus(0, 2, 8'h33);
    applyStimulus(0, 3, 8'h44);
    applyStimulus(0, 0, 8'h11);
    checkOutput(1'b0, 1'b0, 0);
    for (int f = 0; f < 4; f++) checkOutput(1'b0, 1'b0, 13);
    valid_v[0] = '0;

    // No parity, no gap, only requester 2: back-to-back 10-bit frames
    @(negedge clk_uart);
    applyStimulus(1, 2, 8'hFF);
    applyStimulus(1, 2, 8'hFF);
    applyStimulus(1, 2, 8'hFF);
    checkOutput(1'b0, 1'b0, 0);
    checkOutput(1'b0, 1'b0, 11);
    checkOutput(1'b0, 1'b0, 11);
    valid_v[1] = '0;
    repeat (3) @(negedge clk_uart);
    #1;
    checkVal("grant_hold", 32'(grant_v[1]), 32'd2);
    checkVal("nopar_idle_busy", 32'(busy_v[1]), 32'd0);

    // Odd parity: 8'h00 -> 1, 8'h01 -> 0
    @(negedge clk_uart);
    applyStimulus(2, 1, 8'h00);
    checkOutput(1'b1, 1'b0, 0);
    @(negedge clk_uart);
    applyStimulus(2, 1, 8'h01);
    checkOutput(1'b1, 1'b0, 0);

    repeat (3) @(negedge clk_uart);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
